// File: rtl/alu9_pkg.sv
// alu9_pkg: shared op encoding and sign-magnitude widths for alu_9b (ALU9_SAT_EN picks saturate vs wrap on overflow).
package alu9_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MIN = 2'b10, OP_MAX = 2'b11} op_e;
  localparam int W = 9;
  localparam int MAG_W = 8;
  localparam logic [MAG_W-1:0] MAG_MAX = 8'hFF;
endpackage

// File: rtl/sm_addsub.sv
// sm_addsub: combinational sign-magnitude add/sub with numeric compare; ALU9_SAT_EN saturates overflow, else wraps.
module sm_addsub
  import alu9_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] res,
  output logic         ovf,
  output logic         a_lt_b,
  output logic         a_eq_b
);
  logic [MAG_W-1:0] ma, mb, mag;
  logic [MAG_W:0] sum;
  logic sb, same, a_ge, sgn;
  logic signed [MAG_W+1:0] va, vb;
  always_comb begin
    ma = a[MAG_W-1:0];
    mb = b[MAG_W-1:0];
    sb = b[W-1] ^ sub;
    same = a[W-1] == sb;
    sum = {1'b0, ma} + {1'b0, mb};
    a_ge = ma >= mb;
    ovf = same & sum[MAG_W];
`ifdef ALU9_SAT_EN
    mag = same ? (ovf ? MAG_MAX : sum[MAG_W-1:0]) : (a_ge ? ma - mb : mb - ma);
`else
    mag = same ? sum[MAG_W-1:0] : (a_ge ? ma - mb : mb - ma);
`endif
    // a zero magnitude always carries a positive sign
    sgn = (same | a_ge ? a[W-1] : sb) & |mag;
    res = {sgn, mag};
    va = a[W-1] ? -$signed({2'b00, ma}) : $signed({2'b00, ma});
    vb = b[W-1] ? -$signed({2'b00, mb}) : $signed({2'b00, mb});
    a_lt_b = va < vb;
    a_eq_b = va == vb;
  end
endmodule

// File: rtl/alu_9b.sv
// alu_9b: registered 9-bit sign-magnitude ADD/SUB/MIN/MAX with overflow flag; ALU9_SAT_EN selects saturating overflow.
module alu_9b
  import alu9_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   select,
  input  logic [W-1:0] inputA,
  input  logic [W-1:0] inputB,
  input  logic         in_valid,
  output logic [W-1:0] out,
  output logic         out_valid,
  output logic         ovf
);
  op_e op;
  logic [W-1:0] sum_res, nxt;
  logic sum_ovf, a_lt_b, a_eq_b, nxt_ovf;
  assign op = op_e'(select);
  sm_addsub u_addsub (
    .a(inputA),
    .b(inputB),
    .sub(op == OP_SUB),
    .res(sum_res),
    .ovf(sum_ovf),
    .a_lt_b(a_lt_b),
    .a_eq_b(a_eq_b)
  );
  // ties resolve to A for both MIN and MAX
  always_comb begin
    nxt = op == OP_MIN ? (a_lt_b | a_eq_b ? inputA : inputB) :
          op == OP_MAX ? (a_lt_b ? inputB : inputA) : sum_res;
    nxt_ovf = (op == OP_ADD || op == OP_SUB) & sum_ovf;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= nxt;
        ovf <= nxt_ovf;
      end
    end
  end
endmodule

// File: tb/tb_alu_9b.sv
// tb_alu_9b: directed vectors for alu_9b checked against an integer-arithmetic model every cycle.
module tb_alu_9b;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] select = 2'b00;
  logic [8:0] inputA = '0, inputB = '0;
  logic in_valid = 1'b0;
  logic [8:0] out;
  logic out_valid, ovf;
  int checks = 0, errors = 0;
  logic run = 1'b0;
  logic [8:0] e_out;
  logic e_ovf, e_valid;
  always #5 clk = ~clk;
  alu_9b dut (
    .clk(clk), .rst_n(rst_n), .select(select), .inputA(inputA), .inputB(inputB),
    .in_valid(in_valid), .out(out), .out_valid(out_valid), .ovf(ovf)
  );
  function automatic int val(input logic [8:0] x);
    return x[8] ? -int'(x[7:0]) : int'(x[7:0]);
  endfunction
  function automatic logic [9:0] model(input logic [1:0] s, input logic [8:0] a, input logic [8:0] b);
    int r, m;
    logic ov;
    if (s == 2'b10) return {1'b0, (val(b) < val(a)) ? b : a};
    if (s == 2'b11) return {1'b0, (val(b) > val(a)) ? b : a};
    r = (s == 2'b00) ? val(a) + val(b) : val(a) - val(b);
    m = r < 0 ? -r : r;
    ov = m > 255;
`ifdef ALU9_SAT_EN
    if (ov) m = 255;
`else
    m = m % 256;
`endif
    return {ov, (r < 0 && m != 0), 8'(m)};
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_out = '0;
      e_ovf = 1'b0;
      e_valid = 1'b0;
    end else begin
      e_valid = in_valid;
      if (in_valid) {e_ovf, e_out} = model(select, inputA, inputB);
    end
  end
  always @(negedge clk) begin
    if (run) begin
      checks++;
      if (out !== e_out || ovf !== e_ovf || out_valid !== e_valid) begin
        errors++;
        $display("FAIL model t=%0t out=%h ovf=%b vld=%b required out=%h ovf=%b vld=%b",
                 $time, out, ovf, out_valid, e_out, e_ovf, e_valid);
      end
    end
  end
  task automatic apply(input string name, input logic [1:0] s, input logic [8:0] a,
                       input logic [8:0] b, input logic [8:0] eo, input logic eovf);
    @(negedge clk);
    select = s;
    inputA = a;
    inputB = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out !== eo || ovf !== eovf || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s out=%h ovf=%b vld=%b required out=%h ovf=%b vld=1", name, out, ovf, out_valid, eo, eovf);
    end
  endtask
  initial begin
    int pulses;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 9'h000 || ovf !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset out=%h ovf=%b vld=%b required 000/0/0", out, ovf, out_valid);
    end
    run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    apply("add_pp", 2'b00, 9'h003, 9'h002, 9'h005, 1'b0);
    apply("add_pn", 2'b00, 9'h003, 9'h102, 9'h001, 1'b0);
    apply("add_np", 2'b00, 9'h103, 9'h002, 9'h101, 1'b0);
    apply("add_nn", 2'b00, 9'h103, 9'h102, 9'h105, 1'b0);
    apply("sub_pp", 2'b01, 9'h003, 9'h002, 9'h001, 1'b0);
    apply("sub_pn", 2'b01, 9'h003, 9'h102, 9'h005, 1'b0);
    apply("sub_np", 2'b01, 9'h103, 9'h002, 9'h105, 1'b0);
    apply("sub_nn", 2'b01, 9'h103, 9'h102, 9'h101, 1'b0);
    apply("min_nn", 2'b10, 9'h103, 9'h102, 9'h103, 1'b0);
    apply("max_nn", 2'b11, 9'h103, 9'h102, 9'h102, 1'b0);
    apply("max_tie", 2'b11, 9'h100, 9'h000, 9'h100, 1'b0);
    apply("min_tie", 2'b10, 9'h000, 9'h100, 9'h000, 1'b0);
    apply("relu", 2'b11, 9'h105, 9'h000, 9'h000, 1'b0);
    apply("min_pp", 2'b10, 9'h07F, 9'h010, 9'h010, 1'b0);
    apply("zero", 2'b00, 9'h005, 9'h105, 9'h000, 1'b0);
    apply("negzero", 2'b00, 9'h100, 9'h003, 9'h003, 1'b0);
    apply("max_ovf0", 2'b11, 9'h0FF, 9'h0FF, 9'h0FF, 1'b0);
`ifdef ALU9_SAT_EN
    apply("ovf_pos", 2'b00, 9'h0C8, 9'h064, 9'h0FF, 1'b1);
    apply("ovf_neg", 2'b01, 9'h1FF, 9'h001, 9'h1FF, 1'b1);
`else
    apply("ovf_pos", 2'b00, 9'h0C8, 9'h064, 9'h02C, 1'b1);
    apply("ovf_neg", 2'b01, 9'h1FF, 9'h001, 9'h000, 1'b1);
`endif
    apply("edge_255", 2'b00, 9'h0FE, 9'h001, 9'h0FF, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 9'h000 || out_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset out=%h ovf=%b vld=%b required 000/0/0", out, ovf, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    select = 2'b00;
    inputA = 9'h00A;
    inputB = 9'h104;
    in_valid = 1'b1;
    pulses = 0;
    @(posedge clk);
    #1;
    if (out_valid) pulses++;
    @(negedge clk);
    in_valid = 1'b0;
    inputA = 9'h055;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses != 1 || out !== 9'h006) begin
      errors++;
      $display("FAIL pulse pulses=%0d out=%h required pulses=1 out=006", pulses, out);
    end
    @(negedge clk);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
